stopwatch_btn_cond: RTL and testbench

- Front end that generates the start/stop/reset command pulses consumed by the stopwatch control FSM.
- Takes three raw, asynchronous, bouncing push-buttons and synchronizes and debounces each one.
- Emits single-cycle, mutually exclusive, registered command pulses: one pulse per debounced press.
- Sits between the board button pins and the control FSM command inputs.

---
 rtl/stopwatch_btn_cond_pkg.sv | 18 +
 rtl/stopwatch_btn_cond_btn_debounce.sv | 62 ++++++
 rtl/stopwatch_btn_cond.sv | 77 +++++++
 tb/tb_stopwatch_btn_cond.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_btn_cond_pkg.sv
// Shared stopwatch definitions: command indices, command vector width and
// default button-conditioning parameters.
package stopwatch_btn_cond_pkg;

    // Bit positions of each command in the 3-bit command / button vectors.
    localparam int CMD_START = 0;
    localparam int CMD_STOP  = 1;
    localparam int CMD_RESET = 2;

    // Width of the {reset, stop, start} command vector.
    localparam int CMD_W = 3;

    // Defaults: 10 ms debounce at 50 MHz, two-flop synchronizer.
    localparam int DEF_DB_CYCLES   = 500000;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_CNT_W       = 19;

endpackage

// File: rtl/stopwatch_btn_cond_btn_debounce.sv
// Single-button conditioner: synchronizer chain, debounce counter, stable
// level register and rising-edge detector on the stable level.
module btn_debounce #(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 500000,
    parameter int CNT_W       = 19
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic stable,
    output logic press
);

    // Counter value on which the next mismatching cycle accepts the new level.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   level_dly_q, level_dly_d;
    logic                   sync_out;

    assign sync_out = sync_q[SYNC_STAGES-1];

    // Next-state: shift the synchronizer, count consecutive mismatches and
    // accept the new level once the counter has seen DB_CYCLES of them.
    always_comb begin
        sync_d      = {sync_q[SYNC_STAGES-2:0], raw};
        cnt_d       = cnt_q;
        level_d     = level_q;
        level_dly_d = level_q;
        if (sync_out == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d = sync_out;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers, all cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q      <= '0;
            cnt_q       <= '0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            cnt_q       <= cnt_d;
            level_q     <= level_d;
            level_dly_q <= level_dly_d;
        end
    end

    assign stable = level_q;
    // Presses only; releases produce nothing.
    assign press  = level_q & ~level_dly_q;

endmodule

// File: rtl/stopwatch_btn_cond.sv
// Button front end for the stopwatch: conditions three raw buttons and
// issues registered, mutually exclusive one-cycle command pulses.
module stopwatch_btn_cond
    import stopwatch_btn_cond_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int DB_CYCLES   = DEF_DB_CYCLES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start_raw,
    input  logic       btn_stop_raw,
    input  logic       btn_reset_raw,
    output logic       start,
    output logic       stop,
    output logic       reset,
    output logic [2:0] btn_stable,
    output logic       cmd_dropped
);

    logic [CMD_W-1:0] raw_vec;
    logic [CMD_W-1:0] stable_vec;
    logic [CMD_W-1:0] press_vec;
    logic [CMD_W-1:0] cmd_q, cmd_d;
    logic             dropped_q, dropped_d;

    assign raw_vec = {btn_reset_raw, btn_stop_raw, btn_start_raw};

    for (genvar i = 0; i < CMD_W; i++) begin : g_btn
        btn_debounce #(
            .SYNC_STAGES (SYNC_STAGES),
            .DB_CYCLES   (DB_CYCLES),
            .CNT_W       (CNT_W)
        ) u_btn (
            .clk    (clk),
            .rst    (rst),
            .raw    (raw_vec[i]),
            .stable (stable_vec[i]),
            .press  (press_vec[i])
        );
    end

    // Fixed-priority arbitration reset > stop > start; losers are dropped
    // and flagged rather than queued.
    always_comb begin
        cmd_d     = '0;
        dropped_d = 1'b0;
        if (press_vec[CMD_RESET]) begin
            cmd_d[CMD_RESET] = 1'b1;
            dropped_d        = press_vec[CMD_STOP] | press_vec[CMD_START];
        end else if (press_vec[CMD_STOP]) begin
            cmd_d[CMD_STOP] = 1'b1;
            dropped_d       = press_vec[CMD_START];
        end else if (press_vec[CMD_START]) begin
            cmd_d[CMD_START] = 1'b1;
        end
    end

    // Registered command outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_q     <= '0;
            dropped_q <= 1'b0;
        end else begin
            cmd_q     <= cmd_d;
            dropped_q <= dropped_d;
        end
    end

    assign start       = cmd_q[CMD_START];
    assign stop        = cmd_q[CMD_STOP];
    assign reset       = cmd_q[CMD_RESET];
    assign cmd_dropped = dropped_q;
    assign btn_stable  = stable_vec;

endmodule

// File: tb/tb_stopwatch_btn_cond.sv
// Directed bench for stopwatch_btn_cond with SYNC_STAGES=2, DB_CYCLES=4.
// Edge numbering: the first edge that samples a new raw level is edge 1;
// a command pulse is expected to be visible just after edge 7.
module tb_stopwatch_btn_cond;

    logic       clk;
    logic       rst;
    logic       btn_start_raw;
    logic       btn_stop_raw;
    logic       btn_reset_raw;
    logic       start;
    logic       stop;
    logic       reset;
    logic [2:0] btn_stable;
    logic       cmd_dropped;

    int checks = 0;
    int errors = 0;

    stopwatch_btn_cond #(
        .SYNC_STAGES (2),
        .DB_CYCLES   (4),
        .CNT_W       (3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_start_raw (btn_start_raw),
        .btn_stop_raw  (btn_stop_raw),
        .btn_reset_raw (btn_reset_raw),
        .start         (start),
        .stop          (stop),
        .reset         (reset),
        .btn_stable    (btn_stable),
        .cmd_dropped   (cmd_dropped)
    );

    // Clock: 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and sample 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Run n edges and count pulses on each output; record edge of first pulse.
    task automatic run(input int n, output int n_start, output int n_stop,
                       output int n_reset, output int n_drop, output int first_pulse);
        n_start = 0; n_stop = 0; n_reset = 0; n_drop = 0; first_pulse = 0;
        for (int e = 1; e <= n; e++) begin
            tick();
            if (start)       n_start++;
            if (stop)        n_stop++;
            if (reset)       n_reset++;
            if (cmd_dropped) n_drop++;
            if ((start | stop | reset) && first_pulse == 0) first_pulse = e;
        end
    endtask

    int ns, np, nr, nd, fp;

    initial begin
        rst           = 1'b1;
        btn_start_raw = 1'b0;
        btn_stop_raw  = 1'b0;
        btn_reset_raw = 1'b0;
        tick();
        tick();
        chk("reset_outputs", {28'd0, start, stop, reset, cmd_dropped}, 32'h0);
        chk("reset_stable", {29'd0, btn_stable}, 32'h0);
        rst = 1'b0;
        run(5, ns, np, nr, nd, fp);
        chk("idle_pulses", ns + np + nr + nd, 0);

        // Clean start press, checked edge by edge.
        btn_start_raw = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            tick();
            chk($sformatf("clean_start_e%0d", e), {31'd0, start}, {31'd0, (e == 7)});
            chk($sformatf("clean_stable_e%0d", e), {29'd0, btn_stable}, {31'd0, (e >= 6)});
            chk($sformatf("clean_others_e%0d", e), {30'd0, stop, reset}, 32'h0);
        end
        btn_start_raw = 1'b0;
        run(12, ns, np, nr, nd, fp);
        chk("release_no_pulse", ns + np + nr + nd, 0);
        chk("release_stable", {29'd0, btn_stable}, 32'h0);

        // Bouncing stop button: 1,0,1,0 two cycles each, then held.
        for (int b = 0; b < 4; b++) begin
            btn_stop_raw = (b % 2 == 0);
            for (int k = 0; k < 2; k++) begin
                tick();
                chk("bounce_quiet", {29'd0, start, stop, reset}, 32'h0);
            end
        end
        btn_stop_raw = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            tick();
            chk($sformatf("bounce_stop_e%0d", e), {31'd0, stop}, {31'd0, (e == 7)});
            chk("bounce_others", {30'd0, start, reset}, 32'h0);
        end
        btn_stop_raw = 1'b0;
        run(12, ns, np, nr, nd, fp);
        chk("bounce_release", ns + np + nr + nd, 0);

        // Hold 50, release 10, press again 20: two start pulses total.
        btn_start_raw = 1'b1;
        run(50, ns, np, nr, nd, fp);
        chk("hold_start_count", ns, 1);
        chk("hold_start_edge", fp, 7);
        btn_start_raw = 1'b0;
        run(10, ns, np, nr, nd, fp);
        chk("hold_release_count", ns + np + nr, 0);
        btn_start_raw = 1'b1;
        run(20, ns, np, nr, nd, fp);
        chk("repress_start_count", ns, 1);
        chk("repress_start_edge", fp, 7);
        btn_start_raw = 1'b0;
        run(12, ns, np, nr, nd, fp);

        // Simultaneous presses: reset wins, drop flagged.
        btn_start_raw = 1'b1;
        btn_stop_raw  = 1'b1;
        btn_reset_raw = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            tick();
            chk($sformatf("simul_reset_e%0d", e), {31'd0, reset}, {31'd0, (e == 7)});
            chk($sformatf("simul_drop_e%0d", e), {31'd0, cmd_dropped}, {31'd0, (e == 7)});
            chk("simul_start_stop", {30'd0, start, stop}, 32'h0);
        end
        chk("simul_stable", {29'd0, btn_stable}, 32'h7);
        btn_start_raw = 1'b0;
        btn_stop_raw  = 1'b0;
        btn_reset_raw = 1'b0;
        run(12, ns, np, nr, nd, fp);
        chk("simul_release", ns + np + nr + nd, 0);

        // Reset at edge 4 of a start press with the button still held.
        btn_start_raw = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            tick();
            chk("midrst_pre", {31'd0, start}, 32'h0);
        end
        rst = 1'b1;
        for (int e = 4; e <= 6; e++) begin
            tick();
            chk($sformatf("midrst_out_e%0d", e), {28'd0, start, stop, reset, cmd_dropped}, 32'h0);
            chk($sformatf("midrst_stable_e%0d", e), {29'd0, btn_stable}, 32'h0);
        end
        rst = 1'b0;
        run(20, ns, np, nr, nd, fp);
        chk("midrst_start_count", ns, 1);
        chk("midrst_start_edge", fp, 7);
        chk("midrst_others", np + nr + nd, 0);
        btn_start_raw = 1'b0;
        run(12, ns, np, nr, nd, fp);

        // Glitch of DB_CYCLES-1 cycles on reset button is rejected.
        btn_reset_raw = 1'b1;
        run(3, ns, np, nr, nd, fp);
        btn_reset_raw = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            tick();
            chk("glitch_no_reset", {31'd0, reset}, 32'h0);
            chk("glitch_stable", {31'd0, btn_stable[2]}, 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
